// File: rtl/ctrl_mem_load_pkg.sv
// Shared types and sizing for the convolution controller blocks.
// The loader FSM state type lives here so the output controller can decode it as well.
package conv_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        CONV = 1'b1
    } load_state_t;

    localparam int CONV_X_MEM_SIZE       = 8;
    localparam int CONV_F_MEM_SIZE       = 4;
    localparam int CONV_X_MEM_ADDR_WIDTH = 3;
    localparam int CONV_F_MEM_ADDR_WIDTH = 2;
    localparam int CONV_DATA_WIDTH       = 8;

endpackage

// File: rtl/ctrl_mem_load_addr_counter.sv
// Wrapping memory address counter with clear, parallel load and increment.
// Priority is clr > load > incr; wrap is by compare so any SIZE works.
module addr_counter #(
    parameter int SIZE  = 8,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             incr,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(SIZE - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (incr) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ctrl_mem_load.sv
// Loads X and F sample streams into their memories, then hands both address counters
// to conv control until conv_done returns the block to loading.
module ctrl_mem_load
    import conv_pkg::*;
#(
    parameter int X_MEM_SIZE       = CONV_X_MEM_SIZE,
    parameter int F_MEM_SIZE       = CONV_F_MEM_SIZE,
    parameter int X_MEM_ADDR_WIDTH = CONV_X_MEM_ADDR_WIDTH,
    parameter int F_MEM_ADDR_WIDTH = CONV_F_MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH       = CONV_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        s_valid_x,
    output logic                        s_ready_x,
    input  logic [DATA_WIDTH-1:0]       s_data_x,
    input  logic                        s_valid_f,
    output logic                        s_ready_f,
    input  logic [DATA_WIDTH-1:0]       s_data_f,

    output logic                        xmem_wr_en,
    output logic [DATA_WIDTH-1:0]       xmem_wdata,
    output logic [X_MEM_ADDR_WIDTH-1:0] xmem_addr,
    output logic                        fmem_wr_en,
    output logic [DATA_WIDTH-1:0]       fmem_wdata,
    output logic [F_MEM_ADDR_WIDTH-1:0] fmem_addr,

    input  logic                        load_xaddr,
    input  logic [X_MEM_ADDR_WIDTH-1:0] load_xaddr_val,
    input  logic                        en_xaddr_incr,
    input  logic                        en_faddr_incr,
    input  logic                        conv_done,
    output logic                        conv_start
);

    localparam logic [X_MEM_ADDR_WIDTH-1:0] X_LAST = X_MEM_ADDR_WIDTH'(X_MEM_SIZE - 1);
    localparam logic [F_MEM_ADDR_WIDTH-1:0] F_LAST = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);

    load_state_t state_q;
    load_state_t state_d;
    logic        x_full_q;
    logic        x_full_d;
    logic        f_full_q;
    logic        f_full_d;
    logic        conv_start_q;
    logic        conv_start_d;

    logic        in_load;
    logic        in_conv;
    logic        conv_clr;
    logic        x_incr;
    logic        f_incr;

    assign in_load = (state_q == LOAD);
    assign in_conv = (state_q == CONV);

    // Ready depends only on registered state so upstream never sees a valid->ready loop.
    assign s_ready_x  = in_load & ~x_full_q;
    assign s_ready_f  = in_load & ~f_full_q;
    assign xmem_wr_en = s_valid_x & s_ready_x;
    assign fmem_wr_en = s_valid_f & s_ready_f;
    assign xmem_wdata = s_data_x;
    assign fmem_wdata = s_data_f;

    // Counters advance on accepted beats while loading and on conv control strobes
    // while convolving; conv control strobes are ignored during LOAD.
    assign conv_clr = in_conv & conv_done;
    assign x_incr   = in_conv ? en_xaddr_incr : xmem_wr_en;
    assign f_incr   = in_conv ? en_faddr_incr : fmem_wr_en;

    addr_counter #(
        .SIZE  (X_MEM_SIZE),
        .WIDTH (X_MEM_ADDR_WIDTH)
    ) u_xaddr (
        .clk      (clk),
        .reset    (reset),
        .clr      (conv_clr),
        .load     (in_conv & load_xaddr),
        .load_val (load_xaddr_val),
        .incr     (x_incr),
        .cnt      (xmem_addr)
    );

    addr_counter #(
        .SIZE  (F_MEM_SIZE),
        .WIDTH (F_MEM_ADDR_WIDTH)
    ) u_faddr (
        .clk      (clk),
        .reset    (reset),
        .clr      (conv_clr),
        .load     (1'b0),
        .load_val ('0),
        .incr     (f_incr),
        .cnt      (fmem_addr)
    );

    always_comb begin
        state_d  = state_q;
        x_full_d = x_full_q;
        f_full_d = f_full_q;
        unique case (state_q)
            LOAD: begin
                if (x_full_q && f_full_q) begin
                    state_d = CONV;
                end
                if (xmem_wr_en && (xmem_addr == X_LAST)) begin
                    x_full_d = 1'b1;
                end
                if (fmem_wr_en && (fmem_addr == F_LAST)) begin
                    f_full_d = 1'b1;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_d  = LOAD;
                    x_full_d = 1'b0;
                    f_full_d = 1'b0;
                end
            end
            default: state_d = LOAD;
        endcase
        conv_start_d = (state_d == CONV);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOAD;
            x_full_q     <= 1'b0;
            f_full_q     <= 1'b0;
            conv_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_full_q     <= x_full_d;
            f_full_q     <= f_full_d;
            conv_start_q <= conv_start_d;
        end
    end

    assign conv_start = conv_start_q;

endmodule

// File: tb/tb_ctrl_mem_load.sv
// Directed self-checking bench for ctrl_mem_load.
module tb_ctrl_mem_load;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_valid_x, s_valid_f;
    logic       s_ready_x, s_ready_f;
    logic [7:0] s_data_x, s_data_f;
    logic       xmem_wr_en, fmem_wr_en;
    logic [7:0] xmem_wdata, fmem_wdata;
    logic [2:0] xmem_addr;
    logic [1:0] fmem_addr;
    logic       load_xaddr;
    logic [2:0] load_xaddr_val;
    logic       en_xaddr_incr, en_faddr_incr;
    logic       conv_done;
    logic       conv_start;

    int checks   = 0;
    int failures = 0;

    int         x_wr_total = 0;
    int         f_wr_total = 0;
    int         bad_wr     = 0;
    logic [7:0] xmem_model [8];
    logic [7:0] fmem_model [4];

    ctrl_mem_load dut (
        .clk            (clk),
        .reset          (reset),
        .s_valid_x      (s_valid_x),
        .s_ready_x      (s_ready_x),
        .s_data_x       (s_data_x),
        .s_valid_f      (s_valid_f),
        .s_ready_f      (s_ready_f),
        .s_data_f       (s_data_f),
        .xmem_wr_en     (xmem_wr_en),
        .xmem_wdata     (xmem_wdata),
        .xmem_addr      (xmem_addr),
        .fmem_wr_en     (fmem_wr_en),
        .fmem_wdata     (fmem_wdata),
        .fmem_addr      (fmem_addr),
        .load_xaddr     (load_xaddr),
        .load_xaddr_val (load_xaddr_val),
        .en_xaddr_incr  (en_xaddr_incr),
        .en_faddr_incr  (en_faddr_incr),
        .conv_done      (conv_done),
        .conv_start     (conv_start)
    );

    always #5 clk = ~clk;

    // Memory model: captures what the DUT writes, plus any write issued while not ready.
    always @(posedge clk) begin
        if (xmem_wr_en === 1'b1) begin
            xmem_model[xmem_addr] = xmem_wdata;
            x_wr_total++;
            if (s_ready_x !== 1'b1) bad_wr++;
        end
        if (fmem_wr_en === 1'b1) begin
            fmem_model[fmem_addr] = fmem_wdata;
            f_wr_total++;
            if (s_ready_f !== 1'b1) bad_wr++;
        end
    end

    task automatic idle_inputs();
        s_valid_x = 0; s_valid_f = 0; s_data_x = 0; s_data_f = 0;
        load_xaddr = 0; load_xaddr_val = 0; en_xaddr_incr = 0; en_faddr_incr = 0;
        conv_done = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if (conv_start !== 1'b0) begin
            failures++; $display("FAIL reset_conv_start actual=%0b expected=0", conv_start);
        end
        checks++;
        if (xmem_addr !== 3'd0 || fmem_addr !== 2'd0) begin
            failures++; $display("FAIL reset_addr actual x=%0d f=%0d expected x=0 f=0", xmem_addr, fmem_addr);
        end
        checks++;
        if (s_ready_x !== 1'b1 || s_ready_f !== 1'b1) begin
            failures++; $display("FAIL reset_ready actual x=%0b f=%0b expected 1 1", s_ready_x, s_ready_f);
        end
        checks++;
        if (xmem_wr_en !== 1'b0 || fmem_wr_en !== 1'b0) begin
            failures++; $display("FAIL reset_wr_en actual x=%0b f=%0b expected 0 0", xmem_wr_en, fmem_wr_en);
        end
    endtask

    task automatic test_stream();
        int x0;
        int f0;
        x0 = x_wr_total;
        f0 = f_wr_total;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_valid_x = 1; s_data_x = 8'(i + 1);
            s_valid_f = 1; s_data_f = 8'(i + 1);
            #1;
            checks++;
            if (xmem_wr_en !== 1'b1 || xmem_addr !== 3'(i)) begin
                failures++; $display("FAIL stream_x_beat%0d actual wr=%0b addr=%0d expected wr=1 addr=%0d", i, xmem_wr_en, xmem_addr, i);
            end
            checks++;
            if (i < 4) begin
                if (fmem_wr_en !== 1'b1 || fmem_addr !== 2'(i)) begin
                    failures++; $display("FAIL stream_f_beat%0d actual wr=%0b addr=%0d expected wr=1 addr=%0d", i, fmem_wr_en, fmem_addr, i);
                end
            end else begin
                if (s_ready_f !== 1'b0 || fmem_wr_en !== 1'b0) begin
                    failures++; $display("FAIL stream_f_full%0d actual ready=%0b wr=%0b expected 0 0", i, s_ready_f, fmem_wr_en);
                end
            end
        end
        @(negedge clk); #1;
        checks++;
        if (conv_start !== 1'b0 || s_ready_x !== 1'b0 || xmem_wr_en !== 1'b0) begin
            failures++; $display("FAIL stream_after1 actual start=%0b ready=%0b wr=%0b expected 0 0 0", conv_start, s_ready_x, xmem_wr_en);
        end
        @(negedge clk); #1;
        checks++;
        if (conv_start !== 1'b1) begin
            failures++; $display("FAIL stream_conv_start actual=%0b expected=1", conv_start);
        end
        s_valid_x = 0; s_valid_f = 0;
        checks++;
        if (x_wr_total - x0 !== 8 || f_wr_total - f0 !== 4) begin
            failures++; $display("FAIL stream_write_count actual x=%0d f=%0d expected 8 4", x_wr_total - x0, f_wr_total - f0);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (xmem_model[k] !== 8'(k + 1)) begin
                failures++; $display("FAIL stream_xmem%0d actual=%0h expected=%0h", k, xmem_model[k], k + 1);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (fmem_model[k] !== 8'(k + 1)) begin
                failures++; $display("FAIL stream_fmem%0d actual=%0h expected=%0h", k, fmem_model[k], k + 1);
            end
        end
    endtask

    task automatic test_conv_addr();
        logic [1:0] f_exp [5];
        logic [2:0] x_exp [3];
        f_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        x_exp = '{3'd6, 3'd7, 3'd0};
        @(negedge clk);
        checks++;
        if (xmem_addr !== 3'd0 || fmem_addr !== 2'd0) begin
            failures++; $display("FAIL conv_entry_addr actual x=%0d f=%0d expected 0 0", xmem_addr, fmem_addr);
        end
        en_faddr_incr = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (fmem_addr !== f_exp[k]) begin
                failures++; $display("FAIL conv_faddr_step%0d actual=%0d expected=%0d", k, fmem_addr, f_exp[k]);
            end
        end
        en_faddr_incr = 0;
        load_xaddr = 1; load_xaddr_val = 3'd5; en_xaddr_incr = 1;
        @(negedge clk);
        checks++;
        if (xmem_addr !== 3'd5 || fmem_addr !== 2'd1) begin
            failures++; $display("FAIL conv_load_priority actual x=%0d f=%0d expected x=5 f=1", xmem_addr, fmem_addr);
        end
        load_xaddr = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (xmem_addr !== x_exp[k]) begin
                failures++; $display("FAIL conv_xaddr_step%0d actual=%0d expected=%0d", k, xmem_addr, x_exp[k]);
            end
        end
        en_xaddr_incr = 0;
        @(negedge clk);
        checks++;
        if (xmem_addr !== 3'd0 || fmem_addr !== 2'd1 || conv_start !== 1'b1) begin
            failures++; $display("FAIL conv_hold actual x=%0d f=%0d start=%0b expected 0 1 1", xmem_addr, fmem_addr, conv_start);
        end
    endtask

    task automatic test_conv_done();
        load_xaddr = 1; load_xaddr_val = 3'd3; en_faddr_incr = 1;
        @(negedge clk);
        load_xaddr = 0; en_faddr_incr = 0;
        conv_done = 1; en_xaddr_incr = 1;
        @(negedge clk);
        conv_done = 0; en_xaddr_incr = 0;
        #1;
        checks++;
        if (conv_start !== 1'b0 || xmem_addr !== 3'd0 || fmem_addr !== 2'd0) begin
            failures++; $display("FAIL done_clear actual start=%0b x=%0d f=%0d expected 0 0 0", conv_start, xmem_addr, fmem_addr);
        end
        checks++;
        if (s_ready_x !== 1'b1 || s_ready_f !== 1'b1) begin
            failures++; $display("FAIL done_ready actual x=%0b f=%0b expected 1 1", s_ready_x, s_ready_f);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_valid_x = 1; s_data_x = 8'(8'h10 + i);
            #1;
            checks++;
            if (xmem_wr_en !== 1'b1 || xmem_addr !== 3'(i)) begin
                failures++; $display("FAIL reload_x_beat%0d actual wr=%0b addr=%0d expected wr=1 addr=%0d", i, xmem_wr_en, xmem_addr, i);
            end
        end
        @(negedge clk);
        s_valid_x = 0;
        #1;
        checks++;
        if (s_ready_x !== 1'b0 || s_ready_f !== 1'b1 || conv_start !== 1'b0) begin
            failures++; $display("FAIL reload_wait_f actual rx=%0b rf=%0b start=%0b expected 0 1 0", s_ready_x, s_ready_f, conv_start);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid_f = 1; s_data_f = 8'(8'hA0 + i);
            #1;
            checks++;
            if (fmem_wr_en !== 1'b1 || fmem_addr !== 2'(i)) begin
                failures++; $display("FAIL reload_f_beat%0d actual wr=%0b addr=%0d expected wr=1 addr=%0d", i, fmem_wr_en, fmem_addr, i);
            end
        end
        @(negedge clk);
        s_valid_f = 0;
        #1;
        checks++;
        if (conv_start !== 1'b0) begin
            failures++; $display("FAIL reload_start_early actual=%0b expected=0", conv_start);
        end
        @(negedge clk); #1;
        checks++;
        if (conv_start !== 1'b1) begin
            failures++; $display("FAIL reload_conv_start actual=%0b expected=1", conv_start);
        end
        checks++;
        if (xmem_model[7] !== 8'h17 || fmem_model[3] !== 8'hA3 || xmem_model[0] !== 8'h10) begin
            failures++; $display("FAIL reload_data actual x0=%0h x7=%0h f3=%0h expected 10 17 a3", xmem_model[0], xmem_model[7], fmem_model[3]);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] vx_pat;
        logic [31:0] vf_pat;
        int          xn;
        int          fn;
        int          x0;
        int          f0;
        int          b0;
        logic        rx0;
        logic        rf0;
        vx_pat = 32'h5A5A_96C3;
        vf_pat = 32'h2490_8421;
        @(negedge clk);
        conv_done = 1;
        @(negedge clk);
        conv_done = 0;
        xn = 0; fn = 0;
        x0 = x_wr_total; f0 = f_wr_total; b0 = bad_wr;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            s_valid_x = 0; s_valid_f = 0;
            #1;
            rx0 = s_ready_x; rf0 = s_ready_f;
            s_valid_x = vx_pat[c]; s_data_x = 8'(8'h30 + xn);
            s_valid_f = vf_pat[c]; s_data_f = 8'(8'hC0 + fn);
            #1;
            checks++;
            if (s_ready_x !== rx0 || s_ready_x !== (xn < 8) || xmem_wr_en !== (vx_pat[c] && xn < 8)) begin
                failures++; $display("FAIL gaps_x_cycle%0d actual ready=%0b/%0b wr=%0b expected ready=%0b wr=%0b", c, rx0, s_ready_x, xmem_wr_en, xn < 8, vx_pat[c] && xn < 8);
            end
            checks++;
            if (s_ready_f !== rf0 || s_ready_f !== (fn < 4) || fmem_wr_en !== (vf_pat[c] && fn < 4)) begin
                failures++; $display("FAIL gaps_f_cycle%0d actual ready=%0b/%0b wr=%0b expected ready=%0b wr=%0b", c, rf0, s_ready_f, fmem_wr_en, fn < 4, vf_pat[c] && fn < 4);
            end
            if (vx_pat[c] && xn < 8) xn++;
            if (vf_pat[c] && fn < 4) fn++;
        end
        @(negedge clk);
        s_valid_x = 0; s_valid_f = 0;
        checks++;
        if (x_wr_total - x0 !== 8 || f_wr_total - f0 !== 4 || bad_wr !== b0) begin
            failures++; $display("FAIL gaps_write_count actual x=%0d f=%0d bad=%0d expected 8 4 0", x_wr_total - x0, f_wr_total - f0, bad_wr - b0);
        end
        checks++;
        if (xmem_model[4] !== 8'h34 || fmem_model[2] !== 8'hC2 || conv_start !== 1'b1) begin
            failures++; $display("FAIL gaps_data actual x4=%0h f2=%0h start=%0b expected 34 c2 1", xmem_model[4], fmem_model[2], conv_start);
        end
    endtask

    task automatic test_load_ignore();
        @(negedge clk);
        conv_done = 1;
        @(negedge clk);
        conv_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_valid_x = 1; s_data_x = 8'(8'h40 + i);
        end
        @(negedge clk);
        s_valid_x = 0;
        conv_done = 1; en_xaddr_incr = 1; load_xaddr = 1; load_xaddr_val = 3'd6; en_faddr_incr = 1;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (conv_start !== 1'b0 || xmem_addr !== 3'd3 || fmem_addr !== 2'd0) begin
            failures++; $display("FAIL ignore_addr actual start=%0b x=%0d f=%0d expected 0 3 0", conv_start, xmem_addr, fmem_addr);
        end
        checks++;
        if (s_ready_x !== 1'b1 || s_ready_f !== 1'b1) begin
            failures++; $display("FAIL ignore_ready actual x=%0b f=%0b expected 1 1", s_ready_x, s_ready_f);
        end
        @(negedge clk);
        s_valid_x = 1; s_data_x = 8'h43;
        #1;
        checks++;
        if (xmem_wr_en !== 1'b1 || xmem_addr !== 3'd3 || conv_start !== 1'b0) begin
            failures++; $display("FAIL ignore_next_beat actual wr=%0b addr=%0d start=%0b expected 1 3 0", xmem_wr_en, xmem_addr, conv_start);
        end
    endtask

    task automatic test_reset_midload();
        @(negedge clk);
        s_valid_x = 0;
        #1;
        checks++;
        if (xmem_addr !== 3'd4) begin
            failures++; $display("FAIL midload_pre_addr actual=%0d expected=4", xmem_addr);
        end
        @(negedge clk);
        s_valid_x = 1; s_data_x = 8'h44;
        @(negedge clk);
        s_valid_x = 0; reset = 1;
        #1;
        checks++;
        if (xmem_addr !== 3'd5) begin
            failures++; $display("FAIL midload_five_beats actual=%0d expected=5", xmem_addr);
        end
        @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if (xmem_addr !== 3'd0 || s_ready_x !== 1'b1 || conv_start !== 1'b0) begin
            failures++; $display("FAIL midload_reset actual addr=%0d ready=%0b start=%0b expected 0 1 0", xmem_addr, s_ready_x, conv_start);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_valid_x = 1; s_data_x = 8'(8'h50 + i);
            s_valid_f = (i < 4); s_data_f = 8'(8'h60 + i);
            #1;
            checks++;
            if (xmem_wr_en !== 1'b1 || xmem_addr !== 3'(i)) begin
                failures++; $display("FAIL midload_x_beat%0d actual wr=%0b addr=%0d expected wr=1 addr=%0d", i, xmem_wr_en, xmem_addr, i);
            end
        end
        @(negedge clk);
        s_valid_x = 0; s_valid_f = 0;
        @(negedge clk); #1;
        checks++;
        if (conv_start !== 1'b1 || xmem_model[0] !== 8'h50 || xmem_model[5] !== 8'h55 || fmem_model[3] !== 8'h63) begin
            failures++; $display("FAIL midload_reload actual start=%0b x0=%0h x5=%0h f3=%0h expected 1 50 55 63", conv_start, xmem_model[0], xmem_model[5], fmem_model[3]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_conv_addr();
        test_conv_done();
        test_gaps();
        test_load_ignore();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
